// File: rtl/two_power_inv.sv
// ============================================================================
// Module   : two_power_inv
// Brief    : value * 2^(-power) mod modulus by one modular halving per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module two_power_inv #(
  parameter int MOD_WIDTH = 256,
  parameter int POW_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_value,
  input  logic [POW_WIDTH-1:0] i_power,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOOP = 1'b1;

  logic [0:0]           state_q,   state_d;
  logic [POW_WIDTH-1:0] counter_q, counter_d;
  logic [POW_WIDTH-1:0] power_q,   power_d;
  logic [MOD_WIDTH:0]   mod_q,     mod_d;
  logic [MOD_WIDTH:0]   r_q,       r_d;
  logic [MOD_WIDTH:0]   r_sum;
  logic                 done;

  // One extra bit keeps the carry of r + N so the halving is exact.
  assign r_sum = r_q + mod_q;
  assign done  = (counter_q == power_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      power_q   <= '0;
      mod_q     <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      power_q   <= power_d;
      mod_q     <= mod_d;
      r_q       <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid)           state_d = S_LOOP;
      S_LOOP:  if (done && o_ready)   state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    counter_d = counter_q;
    power_d   = power_q;
    mod_d     = mod_q;
    r_d       = r_q;
    if (state_q == S_IDLE) begin
      if (i_valid) begin
        power_d   = i_power;
        mod_d     = {1'b0, i_modulus};
        r_d       = {1'b0, i_value};
        counter_d = '0;
      end
    end else if (!done) begin
      r_d       = (r_q[0] ? r_sum : r_q) >> 1;
      counter_d = counter_q + {{(POW_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    i_ready = (state_q == S_IDLE);
    o_valid = (state_q == S_LOOP) && done;
    o_out   = r_q[MOD_WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_two_power_inv.sv
// ============================================================================
// Module   : tb_two_power_inv
// Brief    : Randomized scoreboard bench for two_power_inv.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_two_power_inv;

  localparam int MW = 256;
  localparam int PW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          i_ready;
  logic [MW-1:0] i_value;
  logic [PW-1:0] i_power;
  logic [MW-1:0] i_modulus;
  logic          o_valid;
  logic          o_ready;
  logic [MW-1:0] o_out;

  two_power_inv #(.MOD_WIDTH(MW), .POW_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_value(i_value),
    .i_power(i_power), .i_modulus(i_modulus),
    .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out)
  );

  typedef struct {
    logic [MW-1:0] out;
    int            due;
    bit            chk;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   prev_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [MW-1:0] rand256();
    logic [MW-1:0] r = '0;
    for (int i = 0; i < MW / 32; i++) r = {r[MW-33:0], 32'($urandom)};
    return r;
  endfunction

  // Multiply by the modular inverse of 2, p times.
  function automatic logic [MW-1:0] ref_model(input logic [MW-1:0] v, input int p, input logic [MW-1:0] n);
    logic [2*MW-1:0] nn, inv2, a;
    nn   = {{MW{1'b0}}, n};
    inv2 = (nn + 1) >> 1;
    a    = {{MW{1'b0}}, v} % nn;
    for (int i = 0; i < p; i++) a = (a * inv2) % nn;
    return a[MW-1:0];
  endfunction

  function automatic logic [MW-1:0] fwd_model(input logic [MW-1:0] v, input int p, input logic [MW-1:0] n);
    logic [2*MW-1:0] nn, a;
    nn = {{MW{1'b0}}, n};
    a  = {{MW{1'b0}}, v} % nn;
    for (int i = 0; i < p; i++) a = (a * 2) % nn;
    return a[MW-1:0];
  endfunction

  // Monitor: samples just after the falling edge, pops on each new result.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_valid = 0;
      end else begin
        if (o_valid) begin
          check("i_ready_while_busy", {255'b0, i_ready}, '0);
          if (!prev_valid) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_result: got %h expected no output", o_out);
            end else begin
              cur = sb_q.pop_front();
              check("latency", MW'(cyc), MW'(cur.due));
              if (cur.chk) check("result", o_out, cur.out);
            end
          end else if (cur.chk) begin
            check("result_stable", o_out, cur.out);
          end
        end
        prev_valid = o_valid;
      end
    end
  end

  // mode 0: random o_ready, 1: always ready, 2: 5-cycle backpressure with stray i_valid
  task automatic run_op(input logic [MW-1:0] v, input int p, input logic [MW-1:0] n,
                        input bit chk, input logic [MW-1:0] ev, input int mode);
    exp_t e;
    bit   ok = 0;
    int   hold = 0;
    @(negedge clk);
    check("i_ready_idle", {255'b0, i_ready}, 1);
    i_valid   = 1'b1;
    i_value   = v;
    i_power   = PW'(p);
    i_modulus = n;
    e.out = ev;
    e.due = cyc + 1 + p;
    e.chk = chk;
    sb_q.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
    i_value = rand256();
    for (int t = 0; t < p + 64; t++) begin
      if (mode == 2) begin
        if (o_valid && hold < 5) begin
          o_ready   = 1'b0;
          i_valid   = 1'b1;
          i_power   = 0;
          i_value   = 3;
          hold++;
        end else begin
          o_ready = o_valid;
          i_valid = 1'b0;
        end
      end else begin
        o_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (i_ready) begin
        ok = 1;
        break;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL completion: got no return to idle expected within %0d cycles", p + 64);
      sb_q.delete();
    end
    if (mode == 2) check("backpressure_hold_cycles", MW'(hold), MW'(5));
  endtask

  initial begin
    logic [MW-1:0] n, v, v0;
    logic [MW-1:0] all1;
    int            p;
    all1      = '1;
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_value   = '0;
    i_power   = '0;
    i_modulus = '0;
    o_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_i_ready", {255'b0, i_ready}, 1);
    check("reset_o_valid", {255'b0, o_valid}, 0);
    check("reset_o_out", o_out, 0);
    rst_n = 1'b1;

    run_op(1, 1, 13, 1, 7, 1);
    run_op(5, 0, 13, 1, 5, 1);
    run_op(3, 4, 13, 1, 1, 1);
    run_op(all1 - 2, 1, all1, 1, all1 - 1, 1);
    run_op(1, 4, 13, 1, 9, 2);

    // Abort mid-operation with an asynchronous reset pulse.
    @(negedge clk);
    i_valid = 1'b1; i_value = 1; i_power = 10; i_modulus = 13; o_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("abort_o_valid", {255'b0, o_valid}, 0);
    check("abort_o_out", o_out, 0);
    check("abort_i_ready", {255'b0, i_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 1, 13, 1, 7, 1);

    for (int k = 0; k < 30; k++) begin
      n = rand256() >> $urandom_range(0, 250);
      n[0] = 1'b1;
      p = int'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        v0 = rand256() % n;
        run_op(fwd_model(v0, p, n), p, n, 1, v0, 0);
      end else begin
        v = rand256() % n;
        run_op(v, p, n, 1, ref_model(v, p, n), 0);
      end
    end

    run_op(20, 5, 12, 0, 0, 0);
    run_op(7, 3, 0, 0, 0, 0);
    run_op(all1, 6, 5, 0, 0, 1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
